// File: rtl/clock_logic_delay_line_var_if.sv
// Control and data bundle for the runtime-tappable delay line.
// The master side drives the line; the slave side is the line itself.
interface clock_logic_delay_line_var_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                   shift_en;
    logic                   flush;
    logic                   valid_in;
    logic [WIDTH-1:0]       data_in;
    logic [SELW-1:0]        tap_sel;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic                   tap_err;
    logic [WIDTH*DEPTH-1:0] taps_out;
    logic [SELW-1:0]        valid_count;

    modport master (
        output shift_en, flush, valid_in, data_in, tap_sel,
        input  data_out, valid_out, tap_err, taps_out, valid_count
    );

    modport slave (
        input  shift_en, flush, valid_in, data_in, tap_sel,
        output data_out, valid_out, tap_err, taps_out, valid_count
    );
endinterface

// File: rtl/clock_logic_delay_line_var.sv
// Delay line of DEPTH stages carrying data plus valid, with stall, flush,
// a runtime tap select and a registered occupancy count.
module clock_logic_delay_line_var #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic clock,
    input logic reset,
    clock_logic_delay_line_var_if.slave bus
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       stage_data [1:DEPTH];
    logic [DEPTH:1]         stage_vld;
    logic [SELW-1:0]        valid_count;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [WIDTH-1:0]       mux_data;
    logic                   mux_vld;
    logic                   mux_err;

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_data[k] <= '0;
            end
            stage_vld   <= '0;
            valid_count <= '0;
        end else if (bus.shift_en) begin
            stage_data[1] <= bus.data_in;
            for (int k = 2; k <= DEPTH; k++) begin
                stage_data[k] <= stage_data[k-1];
            end
            stage_vld <= {stage_vld[DEPTH-1:1], bus.valid_in};
            // Word entering and word leaving cancel out in the count.
            valid_count <= valid_count
                         + SELW'(bus.valid_in)
                         - SELW'(stage_vld[DEPTH]);
        end
    end

    always_comb begin
        mux_data = '0;
        mux_vld  = 1'b0;
        mux_err  = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            if (bus.tap_sel == SELW'(k)) begin
                mux_data = stage_data[k];
                mux_vld  = stage_vld[k];
                mux_err  = 1'b0;
            end
        end
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_taps
        assign taps[k*WIDTH-1 -: WIDTH] = stage_data[k];
    end

    assign bus.data_out    = mux_data;
    assign bus.valid_out   = mux_vld;
    assign bus.tap_err     = mux_err;
    assign bus.taps_out    = taps;
    assign bus.valid_count = valid_count;
endmodule

// File: tb/tb_clock_logic_delay_line_var.sv
// Directed bench for the runtime-tappable delay line (WIDTH=8, DEPTH=16).
// A vector table covers basic moves; hand sequences cover multi-cycle cases.
module tb_clock_logic_delay_line_var;
    localparam int W = 8;
    localparam int D = 16;

    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    logic [W-1:0] md [1:D];
    logic         mv [1:D];

    always #5 clock = ~clock;

    clock_logic_delay_line_var_if #(.WIDTH(W), .DEPTH(D)) bus ();

    clock_logic_delay_line_var #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic       sh;
        logic       fl;
        logic       vi;
        logic [7:0] d;
        logic [4:0] sel;
        logic [7:0] ed;
        logic       ev;
        logic       ee;
        logic [4:0] ec;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int mcount();
        int n = 0;
        for (int k = 1; k <= D; k++) if (mv[k]) n++;
        return n;
    endfunction

    function automatic logic [127:0] mtaps();
        logic [127:0] r = '0;
        for (int k = 1; k <= D; k++) r[k*W-1 -: W] = md[k];
        return r;
    endfunction

    task automatic drive(input logic sh, input logic fl,
                         input logic vi, input logic [7:0] d);
        bus.shift_en = sh;
        bus.flush    = fl;
        bus.valid_in = vi;
        bus.data_in  = d;
    endtask

    // One clock edge; the reference line is advanced from the held inputs.
    task automatic step();
        @(posedge clock);
        if (reset || bus.flush) begin
            for (int k = 1; k <= D; k++) begin
                md[k] = '0;
                mv[k] = 1'b0;
            end
        end else if (bus.shift_en) begin
            for (int k = D; k >= 2; k--) begin
                md[k] = md[k-1];
                mv[k] = mv[k-1];
            end
            md[1] = bus.data_in;
            mv[1] = bus.valid_in;
        end
        #1;
    endtask

    task automatic chk_model(input string name);
        chk({name, ".taps"}, bus.taps_out, mtaps());
        chk({name, ".cnt"}, 128'(bus.valid_count), 128'(mcount()));
    endtask

    always @(negedge clock) begin
        if (armed && reset === 1'b0) begin
            checks++;
            if (!(bus.valid_count <= 5'(D))) begin
                failures++;
                $display("FAIL count_bound got=%0d want<=%0d",
                         bus.valid_count, D);
            end
        end
    end

    initial begin
        int hit;
        reset = 1'b1;
        bus.tap_sel = 5'd0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("rst.data", 128'(bus.data_out), 128'h0);
        chk("rst.valid", 128'(bus.valid_out), 128'h0);
        chk("rst.taps", bus.taps_out, 128'h0);
        chk("rst.cnt", 128'(bus.valid_count), 128'h0);
        chk("rst.err0", 128'(bus.tap_err), 128'h1);
        bus.tap_sel = 5'd5;
        #1;
        chk("rst.err5", 128'(bus.tap_err), 128'h0);
        reset = 1'b0;
        armed = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h11, 5'd1, 8'h11, 1'b1, 1'b0, 5'd1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 5'd2, 8'h11, 1'b1, 1'b0, 5'd2};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h33, 5'd1, 8'h22, 1'b1, 1'b0, 5'd2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h44, 5'd1, 8'h44, 1'b0, 1'b0, 5'd2};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h55, 5'd4, 8'h11, 1'b1, 1'b0, 5'd3};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 1'b0, 1'b1, 5'd3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd17, 8'h00, 1'b0, 1'b1, 5'd3};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 8'h44, 1'b0, 1'b0, 5'd3};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'hFF, 5'd1, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 8'h66, 5'd1, 8'h66, 1'b1, 1'b0, 5'd1};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].sh, vecs[i].fl, vecs[i].vi, vecs[i].d);
            bus.tap_sel = vecs[i].sel;
            step();
            chk($sformatf("vec%0d.data", i), 128'(bus.data_out),
                128'(vecs[i].ed));
            chk($sformatf("vec%0d.valid", i), 128'(bus.valid_out),
                128'(vecs[i].ev));
            chk($sformatf("vec%0d.err", i), 128'(bus.tap_err),
                128'(vecs[i].ee));
            chk($sformatf("vec%0d.cnt", i), 128'(bus.valid_count),
                128'(vecs[i].ec));
        end

        // Latency sweep: one 0xA5 per tap, visible only on edge == tap.
        for (int t = 1; t <= D; t++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            step();
            bus.tap_sel = 5'(t);
            for (int e = 1; e <= t + 1; e++) begin
                if (e == 1) drive(1'b1, 1'b0, 1'b1, 8'hA5);
                else drive(1'b1, 1'b0, 1'b0, 8'h00);
                step();
                chk($sformatf("lat%0d.e%0d.v", t, e), 128'(bus.valid_out),
                    128'(e == t));
                chk($sformatf("lat%0d.e%0d.d", t, e), 128'(bus.data_out),
                    (e == t) ? 128'hA5 : 128'h0);
            end
        end

        // Stall: shift on odd edges only; stalled inputs must be ignored.
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        bus.tap_sel = 5'd4;
        hit = 0;
        for (int e = 1; e <= 20; e++) begin
            int s;
            if (e % 2 == 1) drive(1'b1, 1'b0, 1'b1, 8'((e + 1) / 2));
            else drive(1'b0, 1'b0, 1'b1, 8'hEE);
            step();
            s = (e + 1) / 2;
            chk($sformatf("stall.e%0d.d", e), 128'(bus.data_out),
                (s >= 4) ? 128'(s - 3) : 128'h0);
            chk($sformatf("stall.e%0d.v", e), 128'(bus.valid_out),
                128'(s >= 4));
            chk_model($sformatf("stall.e%0d", e));
            if (hit == 0 && bus.valid_out === 1'b1) hit = e;
        end
        chk("stall.first_edge", 128'(hit), 128'd7);

        // Occupancy climb, saturate, then drain.
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(i));
            step();
            chk($sformatf("occ.up%0d", i), 128'(bus.valid_count),
                128'((i < D) ? i : D));
        end
        for (int i = 1; i <= D; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            step();
            chk($sformatf("occ.dn%0d", i), 128'(bus.valid_count),
                128'(D - i));
        end

        // Flush beats a simultaneous valid shift on a full line.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h80 + 8'(i));
            step();
        end
        chk("fl.full", 128'(bus.valid_count), 128'd16);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("fl.taps", bus.taps_out, 128'h0);
        chk("fl.cnt", 128'(bus.valid_count), 128'h0);
        for (int t = 1; t <= D; t++) begin
            bus.tap_sel = 5'(t);
            #1;
            chk($sformatf("fl.t%0d.v", t), 128'(bus.valid_out), 128'h0);
            chk($sformatf("fl.t%0d.d", t), 128'(bus.data_out), 128'h0);
        end

        // Tap bounds on a full line: stage 1 = 0x1F, so stage 3 = 0x1D.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h10 + 8'(i));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        bus.tap_sel = 5'd0;
        #1;
        chk("tb0.err", 128'(bus.tap_err), 128'h1);
        chk("tb0.d", 128'(bus.data_out), 128'h0);
        chk("tb0.v", 128'(bus.valid_out), 128'h0);
        bus.tap_sel = 5'd17;
        #1;
        chk("tb17.err", 128'(bus.tap_err), 128'h1);
        chk("tb17.d", 128'(bus.data_out), 128'h0);
        chk("tb17.v", 128'(bus.valid_out), 128'h0);
        bus.tap_sel = 5'd3;
        #1;
        chk("tb3.err", 128'(bus.tap_err), 128'h0);
        chk("tb3.d", 128'(bus.data_out), 128'h1D);
        chk("tb3.v", 128'(bus.valid_out), 128'h1);
        chk_model("tb.full");

        // Reset mid-ramp, then 0x40 reaches tap 2 two edges after capture.
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        bus.tap_sel = 5'd2;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h30 + 8'(i));
            step();
        end
        chk("rm.pre", 128'(bus.data_out), 128'h34);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h99);
        step();
        reset = 1'b0;
        chk("rm.d", 128'(bus.data_out), 128'h0);
        chk("rm.v", 128'(bus.valid_out), 128'h0);
        chk("rm.taps", bus.taps_out, 128'h0);
        chk("rm.cnt", 128'(bus.valid_count), 128'h0);
        drive(1'b1, 1'b0, 1'b1, 8'h40);
        step();
        chk("rm.e1.v", 128'(bus.valid_out), 128'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        chk("rm.e2.v", 128'(bus.valid_out), 128'h1);
        chk("rm.e2.d", 128'(bus.data_out), 128'h40);
        chk_model("rm.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_logic_delay_line_var.md
# clock_logic_delay_line_var

Parametrised, runtime-tappable delay line: a WIDTH-bit data word plus a valid bit shifts through DEPTH register stages, and any stage can be selected as the output at run time. It extends the fixed 4-tap, 1-bit delay chain with a shift enable (stall), a flush, valid tracking and a live occupancy count. It sits in the clock/logistic utility group, for pipeline-alignment and latency-matching paths whose required delay is set by software or configuration.

## Interface

- WIDTH, 8, data word width (>=1)
- DEPTH, 16, number of delay stages (>=2)
- SELW, $clog2(DEPTH+1), width of tap_sel and valid_count (derived; do not override)

- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- shift_en  in  1  1 = advance the line this cycle; 0 = hold all stages
- flush  in  1  1 = clear all stages this cycle; has priority over shift_en
- valid_in  in  1  qualifies data_in; captured into stage 1 on a shift
- data_in  in  WIDTH  word captured into stage 1 on a shift
- tap_sel  in  SELW  selected stage, 1..DEPTH
- data_out  out  WIDTH  data of stage tap_sel (combinational mux of registers)
- valid_out  out  1  valid bit of stage tap_sel
- tap_err  out  1  tap_sel is 0 or greater than DEPTH (combinational)
- taps_out  out  WIDTH*DEPTH  all stage data; stage k occupies bits [k*WIDTH-1 : (k-1)*WIDTH]
- valid_count  out  SELW  number of stages whose valid bit is set (registered)

## Operation

- State: stage_data[1..DEPTH] (WIDTH each), stage_vld[1..DEPTH], valid_count.
- Priority per cycle: reset > flush > shift_en > hold.
- reset=1: every stage_data, stage_vld and valid_count is set to 0.
- flush=1 (reset=0): every stage_data and stage_vld is cleared to 0 and valid_count is set to 0; valid_in/data_in of that cycle are discarded.
- shift_en=1 (reset=0, flush=0): stage 1 <= {valid_in, data_in}; stage k <= stage k-1 for k=2..DEPTH; stage DEPTH contents are dropped.
  - valid_count <= valid_count + valid_in - stage_vld[DEPTH].
  - Invalid words (valid_in=0) still shift, and their data is still captured; valid only tags them.
- shift_en=0: all state holds; valid_in/data_in are ignored.
- Output mux: for 1<=tap_sel<=DEPTH, data_out=stage_data[tap_sel], valid_out=stage_vld[tap_sel], tap_err=0. Otherwise data_out=0, valid_out=0, tap_err=1.
- tap_sel may change on any cycle. The change is visible on the outputs in the same cycle, with no glitch-protection or retiming. Stage contents are unaffected.
- valid_count never exceeds DEPTH and never underflows; bench asserts this invariant.

## Timing

- Reset values: data_out=0, valid_out=0, taps_out=0, valid_count=0. tap_err follows tap_sel even during reset.
- Latency: a word presented with shift_en=1 at edge n appears at tap k after the k-th shifting edge, counting edge n as the first.
  - With continuous shift_en=1, tap k shows it k cycles later; tap 1 shows it the cycle after capture.
- Stalls (shift_en=0) extend latency by one cycle per stalled cycle. Data is never lost or duplicated during a stall.
- flush and reset take effect at the edge; outputs read 0 from the following cycle.
- Simultaneous flush and shift_en: flush wins, and the line is empty after the edge.
- Simultaneous shift with valid_in=1 and stage_vld[DEPTH]=1: valid_count is unchanged.
- Reset asserted mid-stream: contents are lost. The first shift after reset release captures normally.

## Test plan

- Latency sweep: WIDTH=8, DEPTH=16, shift_en=1 held. For each tap_sel 1..16, inject one valid word 0xA5 followed by zeros -> valid_out=1 with data_out=0xA5 exactly tap_sel cycles after capture, on that cycle only.
- Stall: tap_sel=4, ramp 0x01,0x02,... with shift_en toggling 1,0,1,0. Outputs are the ramp in order with no gaps or repeats, and each stalled cycle adds one cycle of latency. taps_out matches a reference shift model each cycle.
- Occupancy: feed 20 consecutive valid words into DEPTH=16 -> valid_count climbs 1..16 and stays 16. Then feed valid_in=0 for 16 cycles -> valid_count falls to 0.
- Flush priority: line full with valid_count=16; assert flush and shift_en together with valid_in=1, data 0xFF -> next cycle all taps_out=0, valid_count=0, and valid_out=0 for every tap_sel.
- tap_sel bounds: tap_sel=0 and tap_sel=17 (with a full line) -> tap_err=1, data_out=0, valid_out=0. Switching to tap_sel=3 gives tap_err=0 and the stage 3 data in the same cycle.
- Reset mid-operation: assert reset for one cycle during a ramp -> all outputs 0 the next cycle. The resumed ramp value 0x40 reaches tap 2 exactly 2 cycles after capture.
